// File: rtl/stage_dwrite.sv
// Data write-back stage of the bf pipeline: INC/DEC cell updates, IN/OUT byte
// handshakes, the only DRAM write port, and a last-write bypass register.
module stage_dwrite #(
    parameter int A_WIDTH      = 12,
    parameter int D_WIDTH      = 8,
    parameter int OPCODE_MSB   = 7,
    parameter int OP_INC       = 0,
    parameter int OP_DEC       = 1,
    parameter int OP_INCDP     = 2,
    parameter int OP_DECDP     = 3,
    parameter int OP_IN        = 4,
    parameter int OP_OUT       = 5,
    parameter int OP_LOOPBEGIN = 6,
    parameter int OP_LOOPEND   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_MSB:0]   operation_in,
    input  logic                  drdy_in,
    input  logic [D_WIDTH-1:0]    a_in,
    input  logic [A_WIDTH-1:0]    addr_in,
    output logic                  ack,
    output logic                  dwe,
    output logic [A_WIDTH-1:0]    dwa,
    output logic [D_WIDTH-1:0]    dwd,
    input  logic [D_WIDTH-1:0]    din,
    input  logic                  din_valid,
    output logic                  din_ack,
    output logic [D_WIDTH-1:0]    dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  fwd_valid,
    output logic [A_WIDTH-1:0]    fwd_addr,
    output logic [D_WIDTH-1:0]    fwd_data
);

    typedef enum logic [1:0] {S_IDLE, S_IN, S_OUT} state_t;

    state_t             state, state_next;
    logic               accept;
    logic               dout_valid_q;
    logic [A_WIDTH-1:0] held_addr;

    assign ack     = !reset && (state == S_IDLE);
    assign accept  = drdy_in && ack;
    assign din_ack = (state == S_IN) && din_valid && !reset;
    // The pending byte is withdrawn combinationally so no sink can complete a handshake during reset.
    assign dout_valid = dout_valid_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: next-state gets a default first so every path assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (accept) begin
                if      (operation_in[OP_IN])  state_next = S_IN;
                else if (operation_in[OP_OUT]) state_next = S_OUT;
            end
            S_IN:   if (din_valid) state_next = S_IDLE;
            S_OUT:  if (dout_valid_q && dout_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwe          <= 1'b0;
            dwa          <= '0;
            dwd          <= '0;
            dout         <= '0;
            dout_valid_q <= 1'b0;
            held_addr    <= '0;
            fwd_valid    <= 1'b0;
            fwd_addr     <= '0;
            fwd_data     <= '0;
        end else begin
            dwe <= 1'b0;
            if (dwe) begin
                fwd_valid <= 1'b1;
                fwd_addr  <= dwa;
                fwd_data  <= dwd;
            end
            unique case (state)
                S_IDLE: if (accept) begin
                    if (operation_in[OP_IN]) begin
                        held_addr <= addr_in;
                    end else if (operation_in[OP_OUT]) begin
                        dout         <= a_in;
                        dout_valid_q <= 1'b1;
                    end else if (operation_in[OP_INC]) begin
                        dwe <= 1'b1;
                        dwa <= addr_in;
                        dwd <= a_in + 1'b1;
                    end else if (operation_in[OP_DEC]) begin
                        dwe <= 1'b1;
                        dwa <= addr_in;
                        dwd <= a_in - 1'b1;
                    end
                end
                S_IN: if (din_valid) begin
                    dwe <= 1'b1;
                    dwa <= held_addr;
                    dwd <= din;
                end
                S_OUT: if (dout_valid_q && dout_ready) dout_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_dwrite.sv
// Directed self-checking bench for stage_dwrite: arithmetic wrap, back-to-back
// writes, IN/OUT handshakes, opcode priority, bypass register and reset abort.
module tb_stage_dwrite;

    localparam int A_WIDTH = 12;
    localparam int D_WIDTH = 8;
    localparam logic [7:0] OP_NONE    = 8'h00;
    localparam logic [7:0] OP_INC     = 8'h01;
    localparam logic [7:0] OP_DEC     = 8'h02;
    localparam logic [7:0] OP_IN      = 8'h10;
    localparam logic [7:0] OP_OUT     = 8'h20;
    localparam logic [7:0] OP_LOOPEND = 8'h80;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         operation_in;
    logic               drdy_in;
    logic [D_WIDTH-1:0] a_in;
    logic [A_WIDTH-1:0] addr_in;
    logic               ack;
    logic               dwe;
    logic [A_WIDTH-1:0] dwa;
    logic [D_WIDTH-1:0] dwd;
    logic [D_WIDTH-1:0] din;
    logic               din_valid;
    logic               din_ack;
    logic [D_WIDTH-1:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               fwd_valid;
    logic [A_WIDTH-1:0] fwd_addr;
    logic [D_WIDTH-1:0] fwd_data;

    int errors = 0;
    int checks = 0;

    stage_dwrite #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
        .clk(clk), .reset(reset), .operation_in(operation_in), .drdy_in(drdy_in),
        .a_in(a_in), .addr_in(addr_in), .ack(ack), .dwe(dwe), .dwa(dwa), .dwd(dwd),
        .din(din), .din_valid(din_valid), .din_ack(din_ack), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .fwd_valid(fwd_valid),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [D_WIDTH-1:0] a, input logic [A_WIDTH-1:0] addr);
        operation_in = op;
        a_in         = a;
        addr_in      = addr;
        drdy_in      = 1'b1;
    endtask

    task automatic idle_inputs();
        operation_in = OP_NONE;
        drdy_in      = 1'b0;
    endtask

    initial begin
        reset = 1'b1; operation_in = OP_NONE; drdy_in = 1'b0; a_in = '0; addr_in = '0;
        din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        #1;
        check("ack_low_in_reset", 32'(ack), 32'd0);
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_ack", 32'(ack), 32'd1);
        check("rst_dwe", 32'(dwe), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst_dwa", 32'(dwa), 32'd0);

        // INC wraps 0xFF to 0x00
        issue(OP_INC, 8'hFF, 12'h123);
        step(); idle_inputs();
        check("inc_dwe", 32'(dwe), 32'd1);
        check("inc_dwa", 32'(dwa), 32'h123);
        check("inc_dwd", 32'(dwd), 32'h00);
        check("inc_fwd_not_yet", 32'(fwd_valid), 32'd0);
        step();
        check("inc_dwe_pulse", 32'(dwe), 32'd0);
        check("inc_fwd_valid", 32'(fwd_valid), 32'd1);
        check("inc_fwd_addr", 32'(fwd_addr), 32'h123);
        check("inc_fwd_data", 32'(fwd_data), 32'h00);

        // DEC wrap then INC back-to-back
        issue(OP_DEC, 8'h00, 12'h000);
        step();
        issue(OP_INC, 8'h41, 12'hFFF);
        check("dec_dwe", 32'(dwe), 32'd1);
        check("dec_dwa", 32'(dwa), 32'h000);
        check("dec_dwd", 32'(dwd), 32'hFF);
        step(); idle_inputs();
        check("b2b_dwe", 32'(dwe), 32'd1);
        check("b2b_dwa", 32'(dwa), 32'hFFF);
        check("b2b_dwd", 32'(dwd), 32'h42);
        check("b2b_fwd_addr", 32'(fwd_addr), 32'h000);
        check("b2b_fwd_data", 32'(fwd_data), 32'hFF);
        step();
        check("b2b_dwe_end", 32'(dwe), 32'd0);
        check("b2b_fwd_addr2", 32'(fwd_addr), 32'hFFF);
        check("b2b_fwd_data2", 32'(fwd_data), 32'h42);

        // IN with delayed byte
        issue(OP_IN, 8'h00, 12'h010);
        step(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("in_wait_ack", 32'(ack), 32'd0);
            check("in_wait_dwe", 32'(dwe), 32'd0);
            check("in_wait_din_ack", 32'(din_ack), 32'd0);
            if (i < 2) step();
        end
        din = 8'h5A; din_valid = 1'b1;
        #1;
        check("in_din_ack", 32'(din_ack), 32'd1);
        step();
        din_valid = 1'b0;
        #1;
        check("in_din_ack_once", 32'(din_ack), 32'd0);
        check("in_dwe", 32'(dwe), 32'd1);
        check("in_dwa", 32'(dwa), 32'h010);
        check("in_dwd", 32'(dwd), 32'h5A);
        check("in_ack_back", 32'(ack), 32'd1);
        step();
        check("in_dwe_pulse", 32'(dwe), 32'd0);
        check("in_fwd_data", 32'(fwd_data), 32'h5A);

        // OUT with sink stalled two cycles
        issue(OP_OUT, 8'h21, 12'h0F0);
        step(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("out_valid", 32'(dout_valid), 32'd1);
            check("out_data", 32'(dout), 32'h21);
            check("out_ack_low", 32'(ack), 32'd0);
            check("out_no_write", 32'(dwe), 32'd0);
            if (i == 2) dout_ready = 1'b1;
            else step();
        end
        step();
        dout_ready = 1'b0;
        check("out_valid_drop", 32'(dout_valid), 32'd0);
        check("out_ack_back", 32'(ack), 32'd1);
        check("out_dout_hold", 32'(dout), 32'h21);
        check("out_dwe_none", 32'(dwe), 32'd0);

        // IN has priority over INC
        issue(OP_IN | OP_INC, 8'h10, 12'h055);
        step(); idle_inputs();
        check("prio_no_inc", 32'(dwe), 32'd0);
        check("prio_in_state", 32'(ack), 32'd0);
        din = 8'h77; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("prio_dwe", 32'(dwe), 32'd1);
        check("prio_dwa", 32'(dwa), 32'h055);
        check("prio_dwd", 32'(dwd), 32'h77);
        step();

        // LOOPEND retires silently
        issue(OP_LOOPEND, 8'h09, 12'h200);
        step(); idle_inputs();
        check("loop_dwe", 32'(dwe), 32'd0);
        check("loop_ack", 32'(ack), 32'd1);

        // Reset while in S_OUT
        issue(OP_OUT, 8'h33, 12'h001);
        step(); idle_inputs();
        check("rout_valid", 32'(dout_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("rout_valid_in_reset", 32'(dout_valid), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rout_dout_valid", 32'(dout_valid), 32'd0);
        check("rout_dwe", 32'(dwe), 32'd0);
        check("rout_ack", 32'(ack), 32'd1);
        check("rout_fwd_valid", 32'(fwd_valid), 32'd0);

        // Reset while in S_IN; byte arriving afterwards is ignored
        issue(OP_IN, 8'h00, 12'h0AA);
        step(); idle_inputs();
        check("rin_ack", 32'(ack), 32'd0);
        reset = 1'b1; din = 8'h99; din_valid = 1'b1;
        #1;
        check("rin_din_ack_reset", 32'(din_ack), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rin_din_ack_after", 32'(din_ack), 32'd0);
        check("rin_ack_after", 32'(ack), 32'd1);
        step();
        din_valid = 1'b0;
        check("rin_no_write", 32'(dwe), 32'd0);
        check("rin_fwd_valid", 32'(fwd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
